mod_counter: RTL
================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 1..32.
REQ-002 Parameter MOD, default 16, count modulus; legal range 2..2**WIDTH; q spans 0..MOD-1.
REQ-003 Parameter PRESCALE, default 1, enabled cycles per count step; legal range 1..256.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  count enable; advances the prescaler.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement; sampled on each step.
REQ-008 load  input  1  synchronous load of load_val.
REQ-009 load_val  input  WIDTH  value for load.
REQ-010 clr  input  1  synchronous clear to 0.
REQ-011 q  output  WIDTH  registered count value.
REQ-012 tc  output  1  registered terminal-count pulse.

Function
REQ-013 Priority each cycle SHALL be: rst_n low > clr > load > en-driven step > hold.
REQ-014 Prescaler pre SHALL count 0..PRESCALE-1 on cycles with en=1 and no clr/load; a step occurs on an en=1 cycle with pre==PRESCALE-1; pre then returns to 0.
REQ-015 en=0 SHALL freeze q and pre; tc SHALL be 0 that cycle.
REQ-016 Step with up=1: q<MOD-1 -> q+1; q==MOD-1 -> q=0 and tc=1 in the cycle q shows 0.
REQ-017 Step with up=0: q>0 -> q-1; q==0 -> q=MOD-1 and tc=1 in the cycle q shows MOD-1.
REQ-018 tc SHALL be 1 for exactly one cycle per wrap and 0 in every other cycle.
REQ-019 Latency: q and tc SHALL reflect a step/load/clr on the clock edge after the control is sampled (one cycle).
REQ-020 load SHALL set q=load_val when load_val<MOD, otherwise q=MOD-1; pre=0; tc=0.
REQ-021 clr SHALL set q=0, pre=0, tc=0, regardless of en, load, up.
REQ-022 Direction change between steps SHALL take effect on the next step with no lost or extra step.
REQ-023 Next-value arithmetic SHALL be computed WIDTH+1 bits wide; no overflow when MOD==2**WIDTH.

Reset
REQ-024 rst_n=0 at a rising edge SHALL set q=0, pre=0, tc=0; reset mid-count SHALL discard the pending prescale phase.
REQ-025 First step after rst_n release SHALL occur on the PRESCALE-th en=1 cycle.

Configuration
REQ-026 Macro MOD_COUNTER_SAT_EN defined: at boundary (up at MOD-1, down at 0) step SHALL hold q and pulse tc=1 each boundary step.
REQ-027 MOD_COUNTER_SAT_EN undefined: wrap behaviour of REQ-016/017 SHALL apply; no saturation logic present.

Structure
REQ-028 Shared package mod_counter_pkg SHALL hold default WIDTH/MOD/PRESCALE constants and the direction encoding constants (DIR_UP=1, DIR_DOWN=0).
REQ-029 Sub-module mod_counter_prescale SHALL implement the prescaler (inputs clk, rst_n, en, sync_clr; output step).
REQ-030 Parameter legality SHALL be checked at elaboration; illegal values are an elaboration error.

Verification
REQ-031 WIDTH=4, MOD=10, PRESCALE=1, up=1, en=1 from reset, 12 cycles -> q 1..9,0,1,2; tc=1 only with q=0 on 10th cycle.
REQ-032 MOD=10, q=0, up=0, one step -> q=9, tc=1; next step -> q=8, tc=0.
REQ-033 PRESCALE=3, en=1 continuous -> q increments every 3rd cycle; en dropped for 5 cycles mid-phase -> q and phase frozen, resume without lost step.
REQ-034 MOD=10, load=1 with load_val=12 -> q=9; clr=1 and load=1 same cycle -> q=0; rst_n=0 during count -> q=0, tc=0 next edge.
REQ-035 WIDTH=4, MOD=16, up=1 from q=15 -> q=0, tc=1 (no overflow error); with MOD_COUNTER_SAT_EN -> q stays 15, tc=1 each step.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: constants and types shared by the modulo counter.
//   DEFAULT_WIDTH/MOD/PRESCALE : default parameter values for mod_counter
//   DIR_UP / DIR_DOWN          : encoding of the 'up' direction input
//   op_e                       : per-cycle operation selected by the priority decode
//   pre_width()                : width of the prescaler phase register
package mod_counter_pkg;

    localparam int unsigned     DEFAULT_WIDTH    = 4;
    localparam longint unsigned DEFAULT_MOD      = 16;
    localparam int unsigned     DEFAULT_PRESCALE = 1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        OpHold,
        OpStep,
        OpLoad,
        OpClr
    } op_e;

    // A prescale of 1 still gets a 1-bit phase register so the port list never collapses.
    function automatic int unsigned pre_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/mod_counter_prescale.sv
// mod_counter_prescale: enable prescaler for mod_counter.
// Counts enabled cycles 0..PRESCALE-1 and flags a step on the last one.
// Ports:
//   clk      in  clock, rising edge
//   rst_n    in  synchronous active-low reset, phase returns to 0
//   en       in  count enable; phase frozen while low
//   sync_clr in  synchronous phase clear (load/clear of the counter); suppresses step
//   step     out combinational step strobe for the current cycle
module mod_counter_prescale
    import mod_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic step
);

    localparam int unsigned     PW       = pre_width(PRESCALE);
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q;
        step  = 1'b0;
        if (sync_clr) begin
            pre_d = '0;
        end else if (en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                step  = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: prescaled up/down modulo-MOD counter with load, clear and a
// registered terminal-count pulse.
// Ports:
//   clk       in  clock, rising edge
//   rst_n     in  synchronous active-low reset (q=0, tc=0, prescale phase=0)
//   en        in  count enable, advances the prescaler
//   up        in  direction, DIR_UP=1 increment / DIR_DOWN=0 decrement
//   load      in  synchronous load of load_val (clamped to MOD-1)
//   load_val  in  load value
//   clr       in  synchronous clear to 0, beats load and en
//   q         out registered count, 0..MOD-1
//   tc        out registered one-cycle pulse on wrap
// Build option: define MOD_COUNTER_SAT_EN to saturate at the boundaries
// (q holds, tc still pulses on every boundary step) instead of wrapping.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = DEFAULT_WIDTH,
    parameter longint unsigned MOD      = DEFAULT_MOD,
    parameter int unsigned     PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // Elaboration-time parameter legality.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mod_counter: WIDTH must be in 1..32");
    end
    if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
        $error("mod_counter: MOD must be in 2..2**WIDTH");
    end
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
        $error("mod_counter: PRESCALE must be in 1..256");
    end

    // One extra bit so MOD == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             sync_clr;
    logic             step;
    op_e              op;

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   inc_w;
    logic [WIDTH:0]   dec_w;
    logic             wrap_up;
    logic             wrap_dn;
    logic [WIDTH-1:0] load_q;

    assign sync_clr = clr | load;

    mod_counter_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .step     (step)
    );

    // Wide arithmetic: incrementing MOD-1 reaches MOD_W exactly, and
    // decrementing 0 borrows into the top bit.
    assign q_ext   = {1'b0, q_q};
    assign inc_w   = q_ext + (WIDTH + 1)'(1);
    assign dec_w   = q_ext - (WIDTH + 1)'(1);
    assign wrap_up = (inc_w == MOD_W);
    assign wrap_dn = dec_w[WIDTH];

    // Out-of-range load values clamp to the top of the range.
    assign load_q  = ({1'b0, load_val} < MOD_W) ? load_val : Q_MAX;

    always_comb begin
        op = OpHold;
        if (clr) begin
            op = OpClr;
        end else if (load) begin
            op = OpLoad;
        end else if (step) begin
            op = OpStep;
        end
    end

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        unique case (op)
            OpClr: begin
                q_d = '0;
            end
            OpLoad: begin
                q_d = load_q;
            end
            OpStep: begin
                if (up == DIR_UP) begin
                    if (wrap_up) begin
`ifdef MOD_COUNTER_SAT_EN
                        q_d  = q_q;
`else
                        q_d  = '0;
`endif
                        tc_d = 1'b1;
                    end else begin
                        q_d = inc_w[WIDTH-1:0];
                    end
                end else begin
                    if (wrap_dn) begin
`ifdef MOD_COUNTER_SAT_EN
                        q_d  = q_q;
`else
                        q_d  = Q_MAX;
`endif
                        tc_d = 1'b1;
                    end else begin
                        q_d = dec_w[WIDTH-1:0];
                    end
                end
            end
            default: begin
                q_d  = q_q;
                tc_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q  = q_q;
    assign tc = tc_q;

endmodule
